// File: rtl/mult_control_n.sv
// Sequencer for the add-shift array multiplier: WIDTH ADD/SHIFT step pairs driven by a step counter.
// In signed mode the partial product of the sign bit (last step) is subtracted instead of added.
module mult_control_n #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          ClearA_LoadB,
    input  logic          Run,
    input  logic          M,
    input  logic          Signed_Mode,
    output logic          Clr_XA,
    output logic          Ld_B,
    output logic          Add,
    output logic          Sub,
    output logic          Shift_En,
    output logic          Busy,
    output logic          Done,
    output logic [CW-1:0] Step_Count
);

    typedef enum logic [2:0] {IDLE, START, ADD, SHIFT, HOLD} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          sgn;
    logic [CW-1:0] cnt_inc;
    logic          last_step;

    assign cnt_inc   = cnt + CW'(1);
    assign last_step = (cnt == CW'(WIDTH - 1));

    // HOLD waits for Run to drop so a level-held Run cannot start a second multiply
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
            sgn   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Run) begin
                        state <= START;
                        sgn   <= Signed_Mode;
                    end
                end
                START: begin
                    cnt   <= '0;
                    state <= ADD;
                end
                ADD: begin
                    state <= SHIFT;
                end
                SHIFT: begin
                    cnt   <= cnt_inc;
                    state <= (cnt_inc == CW'(WIDTH)) ? HOLD : ADD;
                end
                HOLD: begin
                    if (!Run) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        Clr_XA   = 1'b0;
        Ld_B     = 1'b0;
        Add      = 1'b0;
        Sub      = 1'b0;
        Shift_En = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
        case (state)
            IDLE: begin
                Clr_XA = ClearA_LoadB;
                Ld_B   = ClearA_LoadB;
            end
            START: begin
                Clr_XA = 1'b1;
                Busy   = 1'b1;
            end
            ADD: begin
                Busy = 1'b1;
                if (M) begin
                    if (last_step && sgn) Sub = 1'b1;
                    else                  Add = 1'b1;
                end
            end
            SHIFT: begin
                Shift_En = 1'b1;
                Busy     = 1'b1;
            end
            HOLD: begin
                Done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign Step_Count = cnt;

endmodule

// File: doc/mult_control_n.md
Name: mult_control_n

Overview:
Parametrised sequencer for the add-shift array multiplier. It generalises the fixed 8-bit control FSM to any operand width, replacing one enumerated state per step with an ADD/SHIFT pair and a step counter. It also adds an explicit clear phase, a signed/unsigned mode, and Busy/Done/Step_Count status. It drives the existing X/A/B register datapath and adder/subtractor.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32.
CW, $clog2(WIDTH+1), derived step-counter width; not overridable.

Ports:
Clk  in  1  clock
Reset  in  1  reset Reset, synchronous, active-high; clock Clk
ClearA_LoadB  in  1  idle-time request: clear X/A and load B from switches
Run  in  1  level start request; must be released before the next multiply
M  in  1  current multiplier LSB (B[0]) from the datapath
Signed_Mode  in  1  1 = two's-complement multiply, 0 = unsigned; sampled on start
Clr_XA  out  1  clear X and A registers
Ld_B  out  1  load B register
Add  out  1  A <= A + S this cycle
Sub  out  1  A <= A - S this cycle
Shift_En  out  1  arithmetic right shift of X:A:B this cycle
Busy  out  1  operation in progress
Done  out  1  result valid in A:B
Step_Count  out  CW  partial products completed, 0..WIDTH

Behaviour:
- States: IDLE, START, ADD, SHIFT, HOLD. Registered state, counter cnt and latched sgn. Outputs are combinational from state, cnt, sgn and M.
- Reset (any state, including mid-operation): next edge gives state=IDLE, cnt=0, sgn=0. In IDLE all outputs are 0 except Clr_XA=Ld_B=ClearA_LoadB.
- IDLE:
  - Clr_XA=Ld_B=ClearA_LoadB.
  - Run=1 -> START and sgn<=Signed_Mode.
  - ClearA_LoadB and Run both high: the load happens this cycle and the start also proceeds.
- START: Clr_XA=1 for exactly one cycle (B is kept); cnt<=0; -> ADD.
- ADD:
  - M=0: no arithmetic.
  - M=1 and cnt<WIDTH-1: Add=1.
  - M=1 and cnt=WIDTH-1: Sub=1 if sgn, else Add=1.
  - -> SHIFT.
- SHIFT: Shift_En=1; cnt<=cnt+1. If cnt+1=WIDTH -> HOLD, else -> ADD.
- HOLD: Done=1, all other controls 0. Stays while Run=1; Run=0 -> IDLE. Run held high never restarts an operation.
- Busy=1 in START, ADD and SHIFT only.
- Add, Sub, Shift_En, Clr_XA are mutually exclusive, except Clr_XA with Ld_B in IDLE.
- ClearA_LoadB is ignored outside IDLE.
- Step_Count=cnt. It holds WIDTH in HOLD and returns to 0 on the next START.
- Latency: Run sampled in IDLE at edge 0 -> Done first high after edge 2*WIDTH+1 (17 cycles for WIDTH=8).
- Signed_Mode changes after START have no effect.
- M is sampled only in ADD.

Test Plan:
- Reset, then ClearA_LoadB=1 in IDLE -> Clr_XA=Ld_B=1 the same cycle and Busy=Done=0. Reset asserted in ADD with cnt=3 -> next cycle IDLE, Step_Count=0, all controls 0.
- WIDTH=8, Signed_Mode=1, M per ADD cycle = 1,0,1,1,0,0,0,1:
  - Add in ADD steps 0,2,3; Sub in step 7.
  - Exactly 8 Shift_En pulses.
  - Done after edge 17.
- Same stimulus with Signed_Mode=0 -> step 7 asserts Add instead of Sub; timing identical.
- Run held high for 40 cycles after Done -> stays in HOLD with Done=1 and no further pulses. Run=0 -> IDLE. Run=1 again -> new START with Clr_XA pulse.
- WIDTH=16, M=1 every step, signed -> 15 Add, 1 Sub, 16 Shift_En; Done after edge 33; Step_Count=16.
- WIDTH=2, M=1,1, unsigned -> Add, Shift_En, Add, Shift_En; Done after edge 5.
